clock_set_ctrl: RTL and testbench

Registered sequencer for the digital-clock time datapath: owns the hour/minute/second registers, runs timekeeping from an internal 1 Hz prescaler, and sequences the set mode. Set mode covers field selection, increment/decrement with wrap, preset load, and run/stop. It sits between the debounced key/button front end (key code plus single-cycle button strobes) and the seven-segment display driver, which consumes `hou`/`min`/`sec` directly.

---
 rtl/clock_set_ctrl.sv | 178 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time datapath and set-mode sequencer for the digital clock: owns hh:mm:ss, runs the
// 1 Hz prescaler, and handles key/button driven field selection, stepping and presets.
module clock_set_ctrl #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BLINK_DIV = CLK_HZ / 4
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       button_negedge1,
    input  logic       button_negedge2,
    output logic [6:0] hou,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic       stop_clk,
    output logic       h,
    output logic       m,
    output logic       s,
    output logic [3:0] led4,
    output logic       blink,
    output logic       tick_1hz
);

    localparam int unsigned PresW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PresW-1:0]  PresMax  = PresW'(CLK_HZ - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {StStop, StRun, StSetH, StSetM, StSetS} state_e;

    state_e            state_q, state_d;
    logic [PresW-1:0]  presc_q, presc_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_d, tick_d;
    logic [6:0]        hou_d, min_d, sec_d;
    logic [3:0]        led4_d;
    logic              stop_clk_d, h_d, m_d, s_d;
    logic              key_hit, in_set, next_in_set, one_button, run_wrap;

    function automatic logic [6:0] step_up(input logic [6:0] v, input logic [6:0] lim);
        return (v >= lim) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] step_down(input logic [6:0] v, input logic [6:0] lim);
        return ((v == 7'd0) || (v > lim)) ? lim : v - 7'd1;
    endfunction

    // State register
    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only recognised key codes count as a key event
    always_comb begin
        state_d = state_q;
        key_hit = 1'b0;
        if (key_valid) begin
            case (key)
                4'd1: begin state_d = StSetH; key_hit = 1'b1; end
                4'd2: begin state_d = StSetM; key_hit = 1'b1; end
                4'd3: begin state_d = StSetS; key_hit = 1'b1; end
                4'd6: begin state_d = StRun;  key_hit = 1'b1; end
                4'd7: begin state_d = StStop; key_hit = 1'b1; end
                default: key_hit = 1'b0;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track state_q
    always_comb begin
        led4_d     = 4'b0101;
        h_d        = 1'b0;
        m_d        = 1'b0;
        s_d        = 1'b0;
        stop_clk_d = (state_d != StRun);
        unique case (state_d)
            StStop: led4_d = 4'b0101;
            StRun:  led4_d = 4'b1000;
            StSetH: begin led4_d = 4'b0001; h_d = 1'b1; end
            StSetM: begin led4_d = 4'b0010; m_d = 1'b1; end
            StSetS: begin led4_d = 4'b0100; s_d = 1'b1; end
            default: led4_d = 4'b0101;
        endcase
    end

    // Prescaler and time fields
    always_comb begin
        in_set     = (state_q == StSetH) || (state_q == StSetM) || (state_q == StSetS);
        one_button = button_negedge1 ^ button_negedge2;
        // Any key event in RUN (leave or restart) swallows a coincident wrap
        run_wrap   = (state_q == StRun) && (presc_q == PresMax) && !key_hit;

        presc_d = '0;
        if ((state_q == StRun) && !key_hit) begin
            presc_d = (presc_q == PresMax) ? '0 : presc_q + PresW'(1);
        end

        hou_d  = hou;
        min_d  = min;
        sec_d  = sec;
        tick_d = 1'b0;
        if (key_hit) begin
            if (key == 4'd7) begin
                hou_d = 7'd12;
                min_d = 7'd12;
                sec_d = 7'd12;
            end
        end else if (in_set && one_button) begin
            case (state_q)
                StSetH: hou_d = button_negedge1 ? step_up(hou, 7'd23) : step_down(hou, 7'd23);
                StSetM: min_d = button_negedge1 ? step_up(min, 7'd59) : step_down(min, 7'd59);
                StSetS: sec_d = button_negedge1 ? step_up(sec, 7'd59) : step_down(sec, 7'd59);
                default: hou_d = hou;
            endcase
        end else if (run_wrap) begin
            tick_d = 1'b1;
            sec_d  = step_up(sec, 7'd59);
            if (sec >= 7'd59) begin
                min_d = step_up(min, 7'd59);
                if (min >= 7'd59) begin
                    hou_d = step_up(hou, 7'd23);
                end
            end
        end
    end

    // Blink restarts on every state change so the field always starts visible
    always_comb begin
        next_in_set = (state_d == StSetH) || (state_d == StSetM) || (state_d == StSetS);
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if ((state_d == state_q) && next_in_set) begin
            if (blink_cnt_q == BlinkMax) begin
                blink_cnt_d = '0;
                blink_d     = ~blink;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
                blink_d     = blink;
            end
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            presc_q     <= '0;
            blink_cnt_q <= '0;
            hou         <= 7'd0;
            min         <= 7'd0;
            sec         <= 7'd0;
            stop_clk    <= 1'b1;
            h           <= 1'b0;
            m           <= 1'b0;
            s           <= 1'b0;
            led4        <= 4'b0101;
            blink       <= 1'b0;
            tick_1hz    <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            hou         <= hou_d;
            min         <= min_d;
            sec         <= sec_d;
            stop_clk    <= stop_clk_d;
            h           <= h_d;
            m           <= m_d;
            s           <= s_d;
            led4        <= led4_d;
            blink       <= blink_d;
            tick_1hz    <= tick_d;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed plus randomized bench for clock_set_ctrl against a seconds-of-day reference model.
module tb_clock_set_ctrl;

    localparam int unsigned CLK_HZ    = 10;
    localparam int unsigned BLINK_DIV = 2;

    logic       clk_50Mhz = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'd0;
    logic       key_valid = 1'b0;
    logic       button_negedge1 = 1'b0;
    logic       button_negedge2 = 1'b0;
    logic [6:0] hou, min, sec;
    logic       stop_clk, h, m, s, blink, tick_1hz;
    logic [3:0] led4;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 STOP, 1 RUN, 2 SET_H, 3 SET_M, 4 SET_S
    int md_mode, md_h, md_m, md_s, md_run_cnt, md_bcnt;
    bit md_blink, md_tick;

    clock_set_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) dut (
        .clk_50Mhz(clk_50Mhz), .rst(rst), .key(key), .key_valid(key_valid),
        .button_negedge1(button_negedge1), .button_negedge2(button_negedge2),
        .hou(hou), .min(min), .sec(sec), .stop_clk(stop_clk),
        .h(h), .m(m), .s(s), .led4(led4), .blink(blink), .tick_1hz(tick_1hz)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input bit r, input int k, input bit kv, input bit b1,
                                       input bit b2);
        int new_mode, tot, lim;
        bit hit;
        if (r) begin
            md_mode = 0; md_h = 0; md_m = 0; md_s = 0;
            md_run_cnt = 0; md_bcnt = 0; md_blink = 0; md_tick = 0;
            return;
        end
        new_mode = md_mode;
        hit = 0;
        md_tick = 0;
        if (kv) begin
            hit = 1;
            if (k == 1) new_mode = 2;
            else if (k == 2) new_mode = 3;
            else if (k == 3) new_mode = 4;
            else if (k == 6) new_mode = 1;
            else if (k == 7) begin new_mode = 0; md_h = 12; md_m = 12; md_s = 12; end
            else hit = 0;
        end
        if (hit) begin
            md_run_cnt = 0;
        end else if (md_mode >= 2 && (b1 != b2)) begin
            lim = (md_mode == 2) ? 24 : 60;
            if (md_mode == 2) md_h = b1 ? (md_h + 1) % lim : (md_h + lim - 1) % lim;
            if (md_mode == 3) md_m = b1 ? (md_m + 1) % lim : (md_m + lim - 1) % lim;
            if (md_mode == 4) md_s = b1 ? (md_s + 1) % lim : (md_s + lim - 1) % lim;
        end else if (md_mode == 1) begin
            md_run_cnt++;
            if (md_run_cnt == CLK_HZ) begin
                md_run_cnt = 0;
                md_tick = 1;
                tot = ((md_h * 60 + md_m) * 60 + md_s + 1) % 86400;
                md_h = tot / 3600;
                md_m = (tot / 60) % 60;
                md_s = tot % 60;
            end
        end
        if (new_mode != md_mode || new_mode < 2) begin
            md_bcnt = 0;
            md_blink = 0;
        end else begin
            md_bcnt++;
            if (md_bcnt == BLINK_DIV) begin
                md_bcnt = 0;
                md_blink = !md_blink;
            end
        end
        md_mode = new_mode;
    endfunction

    task automatic compare_all();
        logic [3:0] led_tab [5];
        logic [2:0] hms_exp;
        led_tab = '{4'b0101, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        hms_exp = (md_mode == 2) ? 3'b100 : (md_mode == 3) ? 3'b010 :
                  (md_mode == 4) ? 3'b001 : 3'b000;
        chk("hou", hou, md_h);
        chk("min", min, md_m);
        chk("sec", sec, md_s);
        chk("stop_clk", stop_clk, (md_mode != 1));
        chk("hms", {h, m, s}, hms_exp);
        chk("led4", led4, led_tab[md_mode]);
        chk("blink", blink, md_blink);
        chk("tick_1hz", tick_1hz, md_tick);
    endtask

    task automatic step(input bit r, input int k, input bit kv, input bit b1, input bit b2);
        rst = r;
        key = k[3:0];
        key_valid = kv;
        button_negedge1 = b1;
        button_negedge2 = b2;
        @(posedge clk_50Mhz);
        model_edge(r, k, kv, b1, b2);
        #1;
        compare_all();
        rst = 1'b0;
        key_valid = 1'b0;
        button_negedge1 = 1'b0;
        button_negedge2 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic press(input int k);
        step(0, k, 1, 0, 0);
    endtask

    task automatic btn(input bit up, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, up, !up);
    endtask

    initial begin
        int kcodes [8];
        int k;
        bit kv;
        kcodes = '{1, 2, 3, 6, 7, 0, 5, 15};

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_led4", led4, 4'b0101);
        chk("reset_stop_clk", stop_clk, 1'b1);

        // First second arrives exactly CLK_HZ edges after the RUN key
        press(6);
        idle(9);
        chk("run_sec_early", sec, 0);
        idle(1);
        chk("run_sec_first", sec, 1);
        chk("run_tick_first", tick_1hz, 1);
        idle(1);
        chk("run_tick_single", tick_1hz, 0);
        idle(589);
        chk("run_min_carry", min, 1);
        chk("run_sec_carry", sec, 0);

        press(7);
        press(1);
        btn(1, 2);
        chk("set_h_hou", hou, 14);
        chk("set_h_led4", led4, 4'b0001);
        chk("set_h_h", h, 1'b1);
        chk("set_h_stop", stop_clk, 1'b1);
        press(2);
        btn(0, 13);
        chk("dec_wrap_min", min, 59);
        chk("dec_wrap_hou", hou, 14);

        // Preset 23:59:59 then roll over
        press(1);
        btn(1, 9);
        press(3);
        btn(0, 13);
        chk("preset_sec", sec, 59);
        press(6);
        idle(10);
        chk("roll_hou", hou, 0);
        chk("roll_min", min, 0);
        chk("roll_sec", sec, 0);

        step(0, 3, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("both_btn_sec", sec, 0);
        step(0, 1, 1, 1, 0);
        chk("key_beats_btn", hou, 0);

        press(2);
        idle(4);
        press(6);
        chk("blink_clear", blink, 0);
        btn(1, 3);
        press(7);
        btn(1, 2);
        btn(0, 1);
        chk("stop_btn_ignored", hou, 12);

        // Reset on the wrap edge wins
        press(6);
        idle(9);
        step(1, 0, 0, 0, 0);
        chk("rst_no_tick", tick_1hz, 0);
        chk("rst_sec", sec, 0);

        for (int i = 0; i < 2500; i++) begin
            kv = ($urandom_range(0, 19) == 0);
            k = ($urandom_range(0, 1) == 0) ? kcodes[$urandom_range(0, 7)] : $urandom_range(0, 15);
            step($urandom_range(0, 399) == 0, k, kv,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
